// File: rtl/beat_if.sv
// Handshake bundle between the beat feeder and its song ROM / display consumer.
// The master side drives control pulses and ROM data; the slave side is the feeder.
interface beat_if;
  logic        start;
  logic        pause;
  logic [3:0]  rom_addr;
  logic [15:0] rom_data;
  logic        tick;
  logic [9:0]  lane;
  logic        note_valid;
  logic        note;
  logic        playing;
  logic        song_done;
  logic [7:0]  beat_index;

  modport master (
    output start, pause, rom_data,
    input  rom_addr, tick, lane, note_valid, note, playing, song_done, beat_index
  );

  modport slave (
    input  start, pause, rom_data,
    output rom_addr, tick, lane, note_valid, note, playing, song_done, beat_index
  );
endinterface

// File: rtl/beat_feeder.sv
// Streams a ROM beat map through a 10-slot note lane, one slot per beat tick,
// with lead-in silence, pause/resume, abort and a trailing flush of the lane.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_FETCH   | preloading map words 0 and 1
// S_LEAD_IN | counting silent ticks before the map enters the lane
// S_PLAY    | shifting one map bit into the lane per tick
// S_PAUSED  | everything frozen until the next pause pulse
// S_FLUSH   | shifting zeros until the last map bit leaves the lane
// S_DONE    | song finished, lane empty
module beat_feeder #(
  parameter int TICK_DIV  = 6250000,
  parameter int MAP_WORDS = 12,
  parameter int LEAD_IN   = 16
) (
  input logic   clk,
  input logic   rst,
  beat_if.slave bus
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int LW = $clog2(LEAD_IN + 1);
  localparam logic [CW-1:0] TICK_MAX  = CW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LEAD_MAX  = LW'(LEAD_IN - 1);
  localparam logic [7:0]    LAST_BEAT = 8'(MAP_WORDS * 16 - 1);
  localparam logic [4:0]    ADDR_END  = 5'(MAP_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LEAD_IN, S_PLAY, S_PAUSED, S_FLUSH, S_DONE
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] tick_cnt, cnt_n;
  logic [LW-1:0] lead_cnt;
  logic [3:0]    flush_cnt;
  logic [1:0]    fetch_cnt;
  logic [4:0]    addr_q;
  logic [15:0]   cur_word, next_word;
  logic [3:0]    bit_ptr;
  logic          ref1, ref2;
  logic [9:0]    lane_q;
  logic [7:0]    beat_q;
  logic          note_q, note_valid_q, tick_q, playing_q, song_done_q;
  logic          counting_q, counting_n, shift, tick_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:    if (bus.start) state_n = S_FETCH;
      S_FETCH:   if (bus.start) state_n = S_IDLE;
                 else if (fetch_cnt == 2'd3) state_n = S_LEAD_IN;
      S_LEAD_IN: if (bus.start) state_n = S_IDLE;
                 else if (tick_q && lead_cnt == LEAD_MAX) state_n = S_PLAY;
      S_PLAY:    if (bus.start) state_n = S_IDLE;
                 else if (tick_q && beat_q == LAST_BEAT) state_n = S_FLUSH;
                 else if (bus.pause) state_n = S_PAUSED;
      S_PAUSED:  if (bus.start) state_n = S_IDLE;
                 else if (bus.pause) state_n = S_PLAY;
      S_FLUSH:   if (bus.start) state_n = S_IDLE;
                 else if (tick_q && flush_cnt == 4'd9) state_n = S_DONE;
      S_DONE:    if (bus.start) state_n = S_FETCH;
      default:   state_n = S_IDLE;
    endcase
  end

  // tick is registered so it lines up with the cycle the counter sits at TICK_MAX
  always_comb begin
    counting_q = state_q inside {S_LEAD_IN, S_PLAY, S_FLUSH};
    counting_n = state_n inside {S_LEAD_IN, S_PLAY, S_FLUSH};
    shift      = tick_q && !bus.start && (state_q == S_PLAY || state_q == S_FLUSH);
    if (counting_q)               cnt_n = (tick_cnt == TICK_MAX) ? '0 : tick_cnt + 1'b1;
    else if (state_q == S_PAUSED) cnt_n = tick_cnt;
    else                          cnt_n = '0;
    if (state_n inside {S_IDLE, S_FETCH, S_DONE}) cnt_n = '0;
    tick_n = counting_n && (cnt_n == TICK_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt     <= '0;
      tick_q       <= 1'b0;
      playing_q    <= 1'b0;
      song_done_q  <= 1'b0;
      note_valid_q <= 1'b0;
      note_q       <= 1'b0;
      lane_q       <= '0;
      beat_q       <= '0;
      bit_ptr      <= '0;
      addr_q       <= '0;
      cur_word     <= '0;
      next_word    <= '0;
      ref1         <= 1'b0;
      ref2         <= 1'b0;
      fetch_cnt    <= '0;
      lead_cnt     <= '0;
      flush_cnt    <= '0;
    end else begin
      tick_cnt     <= cnt_n;
      tick_q       <= tick_n;
      playing_q    <= counting_n;
      song_done_q  <= (state_n == S_DONE) && (state_q != S_DONE);
      note_valid_q <= shift;
      ref1         <= 1'b0;
      ref2         <= ref1;
      fetch_cnt    <= (state_q == S_FETCH) ? fetch_cnt + 2'd1 : 2'd0;
      // ROM answers one cycle after the address is seen, so capture two edges after changing it
      if (ref2) next_word <= (addr_q < ADDR_END) ? bus.rom_data : 16'h0000;
      if (state_q == S_FETCH) begin
        lead_cnt  <= '0;
        flush_cnt <= '0;
        if (fetch_cnt == 2'd1) begin
          cur_word <= bus.rom_data;
          addr_q   <= 5'd1;
          ref1     <= 1'b1;
        end
      end
      if (state_q == S_LEAD_IN && tick_q) lead_cnt <= lead_cnt + 1'b1;
      if (shift) begin
        note_q <= lane_q[0];
        if (state_q == S_PLAY) begin
          lane_q  <= {cur_word[bit_ptr], lane_q[9:1]};
          beat_q  <= beat_q + 8'd1;
          bit_ptr <= bit_ptr + 4'd1;
          if (bit_ptr == 4'd15) begin
            cur_word <= next_word;
            addr_q   <= addr_q + 5'd1;
            ref1     <= 1'b1;
          end
        end else begin
          lane_q    <= {1'b0, lane_q[9:1]};
          flush_cnt <= flush_cnt + 4'd1;
        end
      end
      if (bus.start) begin
        lane_q <= '0;
        addr_q <= '0;
        ref1   <= 1'b0;
        ref2   <= 1'b0;
        if (state_q == S_IDLE || state_q == S_DONE) begin
          beat_q  <= '0;
          bit_ptr <= '0;
        end
      end
    end
  end

  assign bus.rom_addr   = addr_q[3:0];
  assign bus.tick       = tick_q;
  assign bus.lane       = lane_q;
  assign bus.note_valid = note_valid_q;
  assign bus.note       = note_q;
  assign bus.playing    = playing_q;
  assign bus.song_done  = song_done_q;
  assign bus.beat_index = beat_q;
endmodule

// File: tb/tb_beat_feeder.sv
// Directed bench for beat_feeder: a per-cycle vector table for the song start,
// then hand-written sequences for free run, pause, abort, start+pause and reset.
module tb_beat_feeder;
  localparam int TD = 4;
  localparam int MW = 2;
  localparam int LI = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  beat_if bus();

  beat_feeder #(.TICK_DIV(TD), .MAP_WORDS(MW), .LEAD_IN(LI)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [16];
  always @(posedge clk) bus.rom_data <= rom_mem[bus.rom_addr];

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int hit_cnt = 0;
  int width_err = 0;
  logic prev_nv = 1'b0, prev_tick = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    if (bus.song_done) done_cnt++;
    if (bus.note_valid && bus.note) hit_cnt++;
    if ((bus.note_valid && prev_nv) || (bus.tick && prev_tick) || (bus.song_done && prev_done))
      width_err++;
    prev_nv   = bus.note_valid;
    prev_tick = bus.tick;
    prev_done = bus.song_done;
  end

  typedef struct {
    logic       start;
    logic       pause;
    logic [3:0] addr;
    logic       tick;
    logic       playing;
    logic [9:0] lane;
    logic       nv;
    logic [7:0] beat;
  } vec_t;

  vec_t vecs [21];

  function automatic vec_t mk(logic s, logic p, logic [3:0] a, logic t, logic pl,
                              logic [9:0] l, logic nv, logic [7:0] b);
    vec_t v;
    v.start = s; v.pause = p; v.addr = a; v.tick = t; v.playing = pl;
    v.lane = l; v.nv = nv; v.beat = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_nv(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.note_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.note_valid) begin
      checks++;
      failures++;
      $display("FAIL timeout_%s actual=no_shift required=shift", tag);
    end
  endtask

  task automatic pulse(input logic s, input logic p);
    bus.start = s;
    bus.pause = p;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  initial begin
    int k;
    int frozen_err;
    int tick_seen;
    logic [9:0] lane_snap;

    for (int i = 0; i < 16; i++) rom_mem[i] = 16'h0000;
    rom_mem[0] = 16'h0001;
    rom_mem[1] = 16'h8000;
    bus.start = 1'b0;
    bus.pause = 1'b0;

    //            st p  addr tk pl lane    nv beat
    vecs[0]  = mk(1, 0, 0,   0, 0, 10'h000, 0, 0);
    vecs[1]  = mk(0, 0, 0,   0, 0, 10'h000, 0, 0);
    vecs[2]  = mk(0, 1, 1,   0, 0, 10'h000, 0, 0);
    vecs[3]  = mk(0, 0, 1,   0, 0, 10'h000, 0, 0);
    vecs[4]  = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[5]  = mk(0, 1, 1,   0, 1, 10'h000, 0, 0);
    vecs[6]  = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[7]  = mk(0, 0, 1,   1, 1, 10'h000, 0, 0);
    vecs[8]  = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[9]  = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[10] = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[11] = mk(0, 0, 1,   1, 1, 10'h000, 0, 0);
    vecs[12] = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[13] = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[14] = mk(0, 0, 1,   0, 1, 10'h000, 0, 0);
    vecs[15] = mk(0, 0, 1,   1, 1, 10'h000, 0, 0);
    vecs[16] = mk(0, 0, 1,   0, 1, 10'h200, 1, 1);
    vecs[17] = mk(0, 0, 1,   0, 1, 10'h200, 0, 1);
    vecs[18] = mk(0, 0, 1,   0, 1, 10'h200, 0, 1);
    vecs[19] = mk(0, 0, 1,   1, 1, 10'h200, 0, 1);
    vecs[20] = mk(0, 0, 1,   0, 1, 10'h100, 1, 2);

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_lane", 32'(bus.lane), 0);
    chk("rst_tick", 32'(bus.tick), 0);
    chk("rst_playing", 32'(bus.playing), 0);
    chk("rst_beat", 32'(bus.beat_index), 0);
    chk("rst_addr", 32'(bus.rom_addr), 0);
    chk("rst_nv", 32'(bus.note_valid), 0);
    rst = 1'b0;
    @(negedge clk);

    // song start: fetch, lead-in, first two PLAY shifts
    for (int i = 0; i < 21; i++) begin
      bus.start = vecs[i].start;
      bus.pause = vecs[i].pause;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      bus.pause = 1'b0;
      chk($sformatf("v%0d_addr", i), 32'(bus.rom_addr), 32'(vecs[i].addr));
      chk($sformatf("v%0d_tick", i), 32'(bus.tick), 32'(vecs[i].tick));
      chk($sformatf("v%0d_playing", i), 32'(bus.playing), 32'(vecs[i].playing));
      chk($sformatf("v%0d_lane", i), 32'(bus.lane), 32'(vecs[i].lane));
      chk($sformatf("v%0d_nv", i), 32'(bus.note_valid), 32'(vecs[i].nv));
      chk($sformatf("v%0d_beat", i), 32'(bus.beat_index), 32'(vecs[i].beat));
    end

    // free run to the end of the song
    for (int s = 3; s <= 32; s++) begin
      wait_nv("play");
      if (s == 10) chk("lane0_after10", 32'(bus.lane[0]), 1);
      if (s == 11) chk("note_on11", 32'(bus.note), 1);
    end
    chk("flush_beat", 32'(bus.beat_index), 32);
    chk("flush_lane9", 32'(bus.lane[9]), 1);
    chk("flush_playing", 32'(bus.playing), 1);
    for (int f = 1; f <= 10; f++) begin
      wait_nv("flush");
      if (f == 9) chk("done_early", 32'(bus.song_done), 0);
    end
    chk("last_note", 32'(bus.note), 1);
    chk("done_pulse", 32'(bus.song_done), 1);
    chk("done_lane", 32'(bus.lane), 0);
    chk("done_playing", 32'(bus.playing), 0);
    chk("done_beat", 32'(bus.beat_index), 32);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.song_done), 0);
    chk("done_count", 32'(done_cnt), 1);
    chk("hit_count", 32'(hit_cnt), 2);

    // pause at beat 5 for 20 cycles
    pulse(1'b1, 1'b0);
    for (int s = 1; s <= 5; s++) wait_nv("pre_pause");
    chk("pause_beat", 32'(bus.beat_index), 5);
    chk("pause_lane", 32'(bus.lane), 32'h020);
    lane_snap = bus.lane;
    pulse(1'b0, 1'b1);
    chk("paused_playing", 32'(bus.playing), 0);
    frozen_err = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.tick || bus.note_valid || bus.lane != lane_snap || bus.beat_index != 8'd5)
        frozen_err++;
      @(negedge clk);
    end
    chk("paused_frozen", 32'(frozen_err), 0);
    bus.pause = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.pause = 1'b0;
    k = 1;
    while (!bus.tick && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("resume_tick_delay", 32'(k), 3);
    @(negedge clk);
    chk("resume_beat", 32'(bus.beat_index), 6);
    chk("resume_lane", 32'(bus.lane), 32'(lane_snap >> 1));

    // abort during PLAY, then restart
    pulse(1'b1, 1'b0);
    chk("abort_lane", 32'(bus.lane), 0);
    chk("abort_playing", 32'(bus.playing), 0);
    chk("abort_tick", 32'(bus.tick), 0);
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(bus.playing), 0);
    pulse(1'b1, 1'b0);
    chk("restart_addr", 32'(bus.rom_addr), 0);
    chk("restart_beat", 32'(bus.beat_index), 0);
    @(negedge clk);
    @(negedge clk);
    chk("restart_addr1", 32'(bus.rom_addr), 1);

    // start and pause together in PLAY
    wait_nv("sp1");
    wait_nv("sp2");
    chk("sp_lane_before", 32'(bus.lane), 32'h100);
    pulse(1'b1, 1'b1);
    chk("sp_playing", 32'(bus.playing), 0);
    chk("sp_lane", 32'(bus.lane), 0);
    pulse(1'b0, 1'b1);
    tick_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.tick || bus.playing) tick_seen++;
      @(negedge clk);
    end
    chk("sp_is_idle", 32'(tick_seen), 0);

    // asynchronous reset mid-FLUSH
    pulse(1'b1, 1'b0);
    for (int s = 1; s <= 33; s++) wait_nv("to_flush");
    chk("mid_flush_lane", 32'(bus.lane), 32'h100);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_lane", 32'(bus.lane), 0);
    chk("arst_playing", 32'(bus.playing), 0);
    chk("arst_beat", 32'(bus.beat_index), 0);
    chk("arst_tick", 32'(bus.tick), 0);
    chk("arst_nv", 32'(bus.note_valid), 0);
    chk("arst_addr", 32'(bus.rom_addr), 0);
    chk("arst_done", 32'(bus.song_done), 0);
    #1 rst = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_idle", 32'(bus.playing), 0);
    chk("post_rst_lane", 32'(bus.lane), 0);
    chk("total_done", 32'(done_cnt), 1);
    chk("pulse_widths", 32'(width_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/beat_feeder.md
BEAT_FEEDER -- requirements
Module: beat_feeder

Interface
REQ-001 Parameter TICK_DIV, default 6250000, clk cycles per beat tick (50 MHz / 8 Hz); legal range >= 4.
REQ-002 Parameter MAP_WORDS, default 12, number of 16-bit beat-map words per song; legal range 1..15.
REQ-003 Parameter LEAD_IN, default 16, silent ticks before the first map bit enters the lane; legal range >= 1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start  in  1  synchronous one-cycle pulse; start or abort a song.
REQ-007 pause  in  1  synchronous one-cycle pulse; toggles PLAY/PAUSED.
REQ-008 rom_addr  out  4  beat-map word address.
REQ-009 rom_data  in  16  map word, valid exactly one cycle after rom_addr is presented; bit 0 is the earliest beat.
REQ-010 tick  out  1  one-cycle beat strobe.
REQ-011 lane  out  10  upcoming-note window; lane[0] is the beat currently at the hit line.
REQ-012 note_valid  out  1  high with each lane shift; note  out  1  the bit leaving lane[0] on that shift.
REQ-013 playing  out  1  high in LEAD_IN, PLAY, FLUSH.
REQ-014 song_done  out  1  one-cycle pulse on entry to DONE.
REQ-015 beat_index  out  8  count of map bits pushed into lane[9] this song.

Function
REQ-016 States SHALL be IDLE, FETCH, LEAD_IN, PLAY, PAUSED, FLUSH, DONE.
REQ-017 FETCH SHALL drive rom_addr=0, capture cur_word one cycle later, drive rom_addr=1, capture next_word one cycle later (if MAP_WORDS=1, next_word=0), then enter LEAD_IN: 4 cycles total.
REQ-018 Tick counter SHALL count 0..TICK_DIV-1 in LEAD_IN, PLAY, FLUSH; hold in PAUSED; clear to 0 in IDLE, FETCH, DONE; tick=1 in the cycle the counter equals TICK_DIV-1.
REQ-019 LEAD_IN SHALL consume LEAD_IN ticks without shifting lane, then enter PLAY on the last lead-in tick.
REQ-020 Each tick in PLAY SHALL shift lane right by one, lane[9] <= cur_word[bit_ptr], note <= old lane[0], note_valid=1 that cycle, bit_ptr++, beat_index++.
REQ-021 When bit 15 of cur_word is consumed: cur_word <= next_word, bit_ptr <= 0, rom_addr advances by one and next_word is recaptured one cycle later; addresses >= MAP_WORDS SHALL load next_word=0 without ROM read.
REQ-022 After MAP_WORDS*16 bits pushed, SHALL enter FLUSH: 10 further ticks shifting zeros into lane[9], note_valid per tick, then DONE with lane=0 and song_done pulse.
REQ-023 pause in PLAY -> PAUSED (lane, counters, bit_ptr frozen, tick=0); pause in PAUSED -> PLAY resuming the held tick count; pause ignored in all other states.
REQ-024 start in IDLE or DONE -> FETCH with lane, beat_index, bit_ptr cleared; start in FETCH, LEAD_IN, PLAY, PAUSED, FLUSH -> IDLE with lane cleared.
REQ-025 start and pause in same cycle: start SHALL take precedence, pause discarded.
REQ-026 note_valid, tick, song_done SHALL never exceed one cycle high; all outputs registered.

Reset
REQ-027 rst high SHALL immediately force IDLE, lane=0, note=0, note_valid=0, tick=0, playing=0, song_done=0, beat_index=0, rom_addr=0, tick counter=0, independent of clk.
REQ-028 rst asserted mid-song SHALL abandon the song; deassertion SHALL leave the block in IDLE awaiting start.

Verification (TICK_DIV=4, MAP_WORDS=2, LEAD_IN=2, ROM word0=16'h0001, word1=16'h8000)
REQ-029 start pulse -> rom_addr 0 then 1 over 4 cycles, playing=1; first tick 4 cycles later; lane unchanged for 2 ticks.
REQ-030 Free run -> after 1st PLAY tick lane=10'b1000000000; bit reaches lane[0] after 10th PLAY tick; note=1 on 11th; beat_index=32 at FLUSH entry; note=1 again 10 ticks after word1 bit 15 enters; song_done once; lane=0 in DONE.
REQ-031 pause at beat_index=5 for 20 cycles then pause -> no tick/lane change while paused; next tick arrives with remaining tick count preserved.
REQ-032 start during PLAY -> IDLE next cycle, lane=0, playing=0; second start -> fresh FETCH from address 0, beat_index=0.
REQ-033 start and pause same cycle in PLAY -> IDLE, not PAUSED.
REQ-034 rst pulse between clk edges mid-FLUSH -> all outputs at reset values before next edge; no song_done.
